// File: rtl/formula_sqrt_reduce_pkg.sv
// Shared types and helpers for the sqrt-reduce sequencer.
package formula_sqrt_reduce_pkg;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // Result width: one isqrt result plus enough headroom that an N-term sum cannot overflow.
    function automatic int res_w(input int w, input int n);
        return w / 2 + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sqrt_arg_issue_sreg.sv
// Holds arguments 1..N_ARGS-1 of the accepted set and presents them one per issue cycle.
// Argument 0 is issued straight from the input bus in the accept cycle, so it is never stored.
module sqrt_arg_issue_sreg #(
    parameter int N_ARGS = 3,
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [N_ARGS*W-1:0] args,
    output logic [W-1:0]        head
);

    if (N_ARGS > 1) begin : g_sreg
        logic [W-1:0] word_q [N_ARGS-1];
        logic         unused_arg0;

        // Load arg[1..] on accept; on each issue move every word one slot toward the head.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < N_ARGS - 1; k++) word_q[k] <= '0;
            end else if (load) begin
                for (int k = 0; k < N_ARGS - 1; k++) word_q[k] <= args[(k+1)*W +: W];
            end else if (shift) begin
                for (int k = 0; k < N_ARGS - 2; k++) word_q[k] <= word_q[k+1];
                word_q[N_ARGS-2] <= '0;
            end
        end

        assign head        = word_q[0];
        assign unused_arg0 = ^args[W-1:0];
    end else begin : g_none
        logic unused_in;

        assign head      = '0;
        assign unused_in = ^{clk, rst, load, shift, args};
    end

endmodule

// File: rtl/formula_sqrt_reduce_pipe_fsm.sv
// Sequencer computing SUM or MAX of isqrt(arg[i]) over N_ARGS arguments, driving an external
// pipelined isqrt unit with one operand per cycle and folding its results as they return.
//
// Handshake: an argument set transfers on a cycle where arg_vld && arg_rdy; args and mode must be
// stable in that cycle only, and arg_vld is ignored whenever arg_rdy is low. arg_rdy is held low in
// the res_vld cycle, so a new set is accepted no earlier than the cycle after the result strobe,
// giving an accept interval of N_ARGS + ISQRT_LAT + 1 cycles.
module formula_sqrt_reduce_pipe_fsm
    import formula_sqrt_reduce_pkg::*;
#(
    parameter int N_ARGS    = 3,
    parameter int W         = 32,
    parameter int ISQRT_LAT = 16,
    parameter int RES_W     = res_w(W, N_ARGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arg_vld,
    output logic                arg_rdy,
    input  logic [N_ARGS*W-1:0] args,
    input  logic                mode,
    output logic                res_vld,
    output logic [RES_W-1:0]    res,
    output logic                isqrt_x_vld,
    output logic [W-1:0]        isqrt_x,
    input  logic                isqrt_y_vld,
    input  logic [W/2-1:0]      isqrt_y,
    output logic [1:0]          dbg_state
);

    localparam int CW = $clog2(N_ARGS + 1);
    localparam int FW = $clog2(ISQRT_LAT + 1);
    localparam logic [CW-1:0] LAST_IDX   = CW'(N_ARGS - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ISQRT_LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [FW-1:0]    flush_cnt;
    logic [CW-1:0]    issue_cnt;
    logic [CW-1:0]    rcv_cnt;
    logic             mode_q;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_upd;
    logic [RES_W-1:0] y_ext;
    logic [W-1:0]     sreg_head;
    logic             accept;
    logic             consume;
    logic             done;

    assign accept    = (state == IDLE) && arg_vld && arg_rdy;
    // Results are only folded while an operation is in flight; anything seen in FLUSH or IDLE is stale.
    assign consume   = isqrt_y_vld && ((state == ISSUE) || (state == DRAIN));
    assign done      = consume && (rcv_cnt == LAST_IDX);
    assign y_ext     = RES_W'(isqrt_y);
    assign dbg_state = state;

    sqrt_arg_issue_sreg #(
        .N_ARGS (N_ARGS),
        .W      (W)
    ) u_sreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state == ISSUE),
        .args  (args),
        .head  (sreg_head)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= FLUSH;
        else     state <= state_nxt;
    end

    // Next-state: flush the pipe after reset, then accept / issue / drain / back to idle.
    always_comb begin
        state_nxt = state;
        case (state)
            FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = IDLE;
            IDLE:    if (accept) state_nxt = (N_ARGS > 1) ? ISSUE : DRAIN;
            ISSUE: begin
                if (done)                         state_nxt = IDLE;
                else if (issue_cnt == LAST_IDX)   state_nxt = DRAIN;
            end
            DRAIN:   if (done) state_nxt = IDLE;
            default: state_nxt = FLUSH;
        endcase
    end

    // Outputs: ready only in a quiet IDLE cycle; operand 0 goes out combinationally on accept.
    always_comb begin
        arg_rdy     = 1'b0;
        isqrt_x_vld = 1'b0;
        isqrt_x     = '0;
        case (state)
            IDLE: begin
                arg_rdy = !res_vld;
                if (arg_vld && !res_vld) begin
                    isqrt_x_vld = 1'b1;
                    isqrt_x     = args[W-1:0];
                end
            end
            ISSUE: begin
                isqrt_x_vld = 1'b1;
                isqrt_x     = sreg_head;
            end
            default: ;
        endcase
    end

    // Fold one returning isqrt result into the accumulator.
    always_comb begin
        acc_upd = acc;
        if (mode_q == MODE_MAX) acc_upd = (y_ext > acc) ? y_ext : acc;
        else                    acc_upd = acc + y_ext;
    end

    // Datapath registers: counters, latched mode, accumulator and the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            mode_q    <= MODE_SUM;
            acc       <= '0;
            res       <= '0;
            res_vld   <= 1'b0;
        end else begin
            res_vld <= done;
            if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
            if (accept) begin
                mode_q    <= mode;
                acc       <= '0;
                issue_cnt <= CW'(1);
                rcv_cnt   <= '0;
            end
            if (state == ISSUE) issue_cnt <= issue_cnt + CW'(1);
            if (consume) begin
                acc     <= acc_upd;
                rcv_cnt <= rcv_cnt + CW'(1);
            end
            if (done) res <= acc_upd;
        end
    end

endmodule

// File: tb/tb_formula_sqrt_reduce_pipe_fsm.sv
// Bench for formula_sqrt_reduce_pipe_fsm: three instances (N=3/L=16, N=8/L=2, N=1/L=1), each
// wired to a behavioural isqrt pipeline, checked against a plain-arithmetic reduce model.
module tb_formula_sqrt_reduce_pipe_fsm;
    import formula_sqrt_reduce_pkg::*;

    localparam int W  = 32;
    localparam int NA = 3, LA = 16, RA = 16 + $clog2(NA + 1);
    localparam int NB = 8, LB = 2,  RB = 16 + $clog2(NB + 1);
    localparam int NC = 1, LC = 1,  RC = 16 + $clog2(NC + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic            vld_a, rdy_a, mode_a, res_vld_a, xv_a, yv_a, inj_a;
    logic [NA*W-1:0] args_a;
    logic [RA-1:0]   res_a;
    logic [W-1:0]    x_a;
    logic [15:0]     y_a, inj_y_a;
    logic [1:0]      st_a;

    logic            vld_b, rdy_b, mode_b, res_vld_b, xv_b, yv_b;
    logic [NB*W-1:0] args_b;
    logic [RB-1:0]   res_b;
    logic [W-1:0]    x_b;
    logic [15:0]     y_b;
    logic [1:0]      st_b;

    logic            vld_c, rdy_c, mode_c, res_vld_c, xv_c, yv_c;
    logic [NC*W-1:0] args_c;
    logic [RC-1:0]   res_c;
    logic [W-1:0]    x_c;
    logic [15:0]     y_c;
    logic [1:0]      st_c;

    formula_sqrt_reduce_pipe_fsm #(.N_ARGS(NA), .W(W), .ISQRT_LAT(LA)) dut_a (
        .clk(clk), .rst(rst), .arg_vld(vld_a), .arg_rdy(rdy_a), .args(args_a), .mode(mode_a),
        .res_vld(res_vld_a), .res(res_a), .isqrt_x_vld(xv_a), .isqrt_x(x_a),
        .isqrt_y_vld(yv_a), .isqrt_y(y_a), .dbg_state(st_a));

    formula_sqrt_reduce_pipe_fsm #(.N_ARGS(NB), .W(W), .ISQRT_LAT(LB)) dut_b (
        .clk(clk), .rst(rst), .arg_vld(vld_b), .arg_rdy(rdy_b), .args(args_b), .mode(mode_b),
        .res_vld(res_vld_b), .res(res_b), .isqrt_x_vld(xv_b), .isqrt_x(x_b),
        .isqrt_y_vld(yv_b), .isqrt_y(y_b), .dbg_state(st_b));

    formula_sqrt_reduce_pipe_fsm #(.N_ARGS(NC), .W(W), .ISQRT_LAT(LC)) dut_c (
        .clk(clk), .rst(rst), .arg_vld(vld_c), .arg_rdy(rdy_c), .args(args_c), .mode(mode_c),
        .res_vld(res_vld_c), .res(res_c), .isqrt_x_vld(xv_c), .isqrt_x(x_c),
        .isqrt_y_vld(yv_c), .isqrt_y(y_c), .dbg_state(st_c));

    // ---------------- reference arithmetic ----------------
    function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
        longint r, t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r + (longint'(1) << b);
            if (t * t <= longint'({32'd0, x})) r = t;
        end
        return r[15:0];
    endfunction

    function automatic logic [63:0] ref_reduce(input logic [255:0] a, input int n, input logic m);
        longint acc, s;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            s = longint'({48'd0, isqrt_ref(a[i*32 +: 32])});
            if (m == MODE_MAX) acc = (s > acc) ? s : acc;
            else               acc = acc + s;
        end
        return acc;
    endfunction

    // ---------------- behavioural isqrt pipelines (not reset: stale results must flow out) ----------------
    logic [LA-1:0]       pv_a = '0;
    logic [LA-1:0][15:0] pd_a = '0;
    logic [LB-1:0]       pv_b = '0;
    logic [LB-1:0][15:0] pd_b = '0;
    logic [LC-1:0]       pv_c = '0;
    logic [LC-1:0][15:0] pd_c = '0;

    always @(posedge clk) begin
        for (int i = LA - 1; i > 0; i--) begin pv_a[i] <= pv_a[i-1]; pd_a[i] <= pd_a[i-1]; end
        pv_a[0] <= xv_a; pd_a[0] <= isqrt_ref(x_a);
        for (int i = LB - 1; i > 0; i--) begin pv_b[i] <= pv_b[i-1]; pd_b[i] <= pd_b[i-1]; end
        pv_b[0] <= xv_b; pd_b[0] <= isqrt_ref(x_b);
        for (int i = LC - 1; i > 0; i--) begin pv_c[i] <= pv_c[i-1]; pd_c[i] <= pd_c[i-1]; end
        pv_c[0] <= xv_c; pd_c[0] <= isqrt_ref(x_c);
    end

    assign yv_a = pv_a[LA-1] | inj_a;
    assign y_a  = inj_a ? inj_y_a : pd_a[LA-1];
    assign yv_b = pv_b[LB-1];
    assign y_b  = pd_b[LB-1];
    assign yv_c = pv_c[LC-1];
    assign y_c  = pd_c[LC-1];

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_exp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_arg();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Offer a set to instance A, check the issued operand stream and the result.
    // After the first issue cycle the inputs switch to nxt with arg_vld = keep.
    task automatic op_a(input string tag, input logic [NA*W-1:0] a, input logic m,
                        input logic [NA*W-1:0] nxt, input bit keep, output int t_acc);
        int   n;
        logic rdy_bad, x_bad;
        logic [63:0] e;
        args_a = a; mode_a = m; vld_a = 1'b1;
        #1;
        n = 0;
        while (!rdy_a && n < 400) begin tick(); n++; end
        chk({tag, "_accept"}, rdy_a, 1'b1);
        t_acc = cyc;
        chk({tag, "_x0_vld"}, xv_a, 1'b1);
        chk({tag, "_x0"}, x_a, a[31:0]);
        exp_q.push_back(ref_reduce(256'(a), NA, m));
        for (int k = 1; k < NA; k++) begin
            tick();
            chk({tag, "_xk_vld"}, xv_a, 1'b1);
            chk({tag, "_xk"}, x_a, a[k*W +: W]);
            chk({tag, "_rdy_issue"}, rdy_a, 1'b0);
            if (k == 1) begin args_a = nxt; vld_a = keep; end
        end
        n = 0; rdy_bad = 1'b0; x_bad = 1'b0;
        do begin
            tick(); n++;
            if (rdy_a) rdy_bad = 1'b1;
            if (xv_a)  x_bad   = 1'b1;
        end while (!res_vld_a && n < 400);
        chk({tag, "_rdy_low"}, rdy_bad, 1'b0);
        chk({tag, "_x_quiet"}, x_bad, 1'b0);
        chk({tag, "_res_vld"}, res_vld_a, 1'b1);
        chk({tag, "_latency"}, 64'(cyc - t_acc), 64'(NA + LA));
        e = exp_q.pop_front();
        chk({tag, "_res"}, res_a, e);
        last_exp = e;
    endtask

    // Single operation on instance B (sel=1) or C (sel=2).
    task automatic op_small(input string tag, input int sel, input logic [255:0] a, input logic m);
        int   n, t0, nn, ll;
        logic [63:0] e;
        if (sel == 1) begin args_b = a[NB*W-1:0]; mode_b = m; vld_b = 1'b1; nn = NB; ll = LB; end
        else          begin args_c = a[NC*W-1:0]; mode_c = m; vld_c = 1'b1; nn = NC; ll = LC; end
        #1;
        n = 0;
        while (!((sel == 1) ? rdy_b : rdy_c) && n < 400) begin tick(); n++; end
        chk({tag, "_accept"}, (sel == 1) ? rdy_b : rdy_c, 1'b1);
        t0 = cyc;
        e  = ref_reduce(a, nn, m);
        tick();
        vld_b = 1'b0; vld_c = 1'b0;
        n = 0;
        while (!((sel == 1) ? res_vld_b : res_vld_c) && n < 400) begin tick(); n++; end
        chk({tag, "_res_vld"}, (sel == 1) ? res_vld_b : res_vld_c, 1'b1);
        chk({tag, "_latency"}, 64'(cyc - t0), 64'(nn + ll));
        chk({tag, "_res"}, (sel == 1) ? 64'(res_b) : 64'(res_c), e);
        last_exp = e;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int t1, t2, n;
        logic [NA*W-1:0] ra;
        logic [255:0]    wide;

        vld_a = 0; args_a = '0; mode_a = MODE_SUM; inj_a = 0; inj_y_a = '0;
        vld_b = 0; args_b = '0; mode_b = MODE_SUM;
        vld_c = 0; args_c = '0; mode_c = MODE_SUM;
        rst = 1'b1;
        repeat (3) tick();

        // reset values
        chk("rst_arg_rdy", rdy_a, 1'b0);
        chk("rst_res_vld", res_vld_a, 1'b0);
        chk("rst_res", res_a, '0);
        chk("rst_x_vld", xv_a, 1'b0);
        chk("rst_x", x_a, '0);
        chk("rst_state", st_a, FLUSH);

        // flush length after reset release
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!rdy_a && n < 400);
        chk("flush_len", n, LA);
        chk("idle_state", st_a, IDLE);
        chk("idle_b", st_b, IDLE);
        chk("idle_c", st_c, IDLE);

        // basic SUM and MAX
        op_a("t1_sum", {32'd16, 32'd9, 32'd4}, MODE_SUM, '0, 1'b0, t1);
        chk("t1_lit", res_a, 64'd9);
        tick();
        chk("t1_pulse", res_vld_a, 1'b0);
        chk("t1_hold", res_a, last_exp);
        op_a("t2_max", {32'd16, 32'd9, 32'd4}, MODE_MAX, '0, 1'b0, t1);
        chk("t2_lit", res_a, 64'd4);

        // isqrt_y_vld while idle must not disturb the held result
        inj_a = 1'b1; inj_y_a = 16'h1234;
        tick();
        inj_a = 1'b0;
        tick();
        chk("idle_y_res", res_a, last_exp);
        chk("idle_y_vld", res_vld_a, 1'b0);

        op_a("t2_zero", '0, MODE_SUM, '0, 1'b0, t1);

        // back-to-back with arg_vld held high; second set offered while busy is ignored until ready
        op_a("t3_ones", {32'd1, 32'd1, 32'd1}, MODE_SUM, {32'hFFFF_FFFF, 32'd25, 32'd100}, 1'b1, t1);
        chk("t3_lit1", res_a, 64'd3);
        op_a("t3_big", {32'hFFFF_FFFF, 32'd25, 32'd100}, MODE_SUM, '0, 1'b0, t2);
        chk("t3_lit2", res_a, 64'd65550);
        chk("t3_interval", 64'(t2 - t1), 64'(NA + LA + 1));

        // reset two cycles into an operation, then offer a new set immediately
        tick();
        args_a = {32'd9, 32'd8, 32'd7}; mode_a = MODE_SUM; vld_a = 1'b1;
        #1;
        n = 0;
        while (!rdy_a && n < 400) begin tick(); n++; end
        chk("t5_accept", rdy_a, 1'b1);
        tick();
        vld_a = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_res", res_a, '0);
        chk("t5_rst_vld", res_vld_a, 1'b0);
        chk("t5_rst_rdy", rdy_a, 1'b0);
        chk("t5_rst_x", xv_a, 1'b0);
        tick();
        rst = 1'b0;
        args_a = {32'd16, 32'd16, 32'd16}; vld_a = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!rdy_a && n < 400);
        chk("t5_flush_len", n, LA);
        op_a("t5_after", {32'd16, 32'd16, 32'd16}, MODE_SUM, '0, 1'b0, t1);
        chk("t5_lit", res_a, 64'd12);

        // randomized operations
        for (int i = 0; i < 6; i++) begin
            ra = {rnd_arg(), rnd_arg(), rnd_arg()};
            op_a("rnd_a", ra, 1'($urandom_range(0, 1)), '0, 1'b0, t1);
        end

        // N_ARGS = 8: full-scale SUM must not overflow, then random sets
        wide = {8{32'hFFFF_FFFF}};
        op_small("t6_b_sum_max", 1, wide, MODE_SUM);
        chk("t6_b_lit", res_b, 64'd524280);
        for (int i = 0; i < 3; i++) begin
            wide = '0;
            for (int k = 0; k < NB; k++) wide[k*32 +: 32] = rnd_arg();
            op_small("rnd_b", 1, wide, 1'($urandom_range(0, 1)));
        end

        // N_ARGS = 1, ISQRT_LAT = 1
        wide = '0; wide[31:0] = 32'hFFFF_FFFF;
        op_small("t6_c_max", 2, wide, MODE_SUM);
        chk("t6_c_lit", res_c, 64'd65535);
        for (int i = 0; i < 3; i++) begin
            wide = '0; wide[31:0] = rnd_arg();
            op_small("rnd_c", 2, wide, 1'($urandom_range(0, 1)));
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: every wait above is bounded, this only guards against a stuck bench.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
